// File: rtl/mlp_host_pkg.sv
// Shared types and load-map helpers for the MLP host controller.
// Region bases follow the load order: weights1, biases1, weights2, biases2, data_in.
package mlp_host_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    RGN_W1  = 3'd0,
    RGN_B1  = 3'd1,
    RGN_W2  = 3'd2,
    RGN_B2  = 3'd3,
    RGN_DIN = 3'd4
  } region_t;

  function automatic int n_load(int i, int h, int o, int c);
    return i*h + c*h + h*o + c*o + c*i;
  endfunction

  function automatic int base_b1(int i, int h, int o, int c);
    return i*h;
  endfunction

  function automatic int base_w2(int i, int h, int o, int c);
    return i*h + c*h;
  endfunction

  function automatic int base_b2(int i, int h, int o, int c);
    return i*h + c*h + h*o;
  endfunction

  function automatic int base_din(int i, int h, int o, int c);
    return i*h + c*h + h*o + c*o;
  endfunction

  // Index width that stays at least one bit even for a single-entry range.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_load_decoder.sv
// Maps a flat load index onto the target array and the element offset within it.
module mlp_load_decoder
  import mlp_host_pkg::*;
#(
  parameter int INPUT_SIZE  = 4,
  parameter int HIDDEN_SIZE = 4,
  parameter int OUTPUT_SIZE = 1,
  parameter int COUNT       = 1,
  parameter int IW          = idx_w(n_load(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE, COUNT))
) (
  input  logic [IW-1:0] load_idx,
  output region_t       region,
  output logic [IW-1:0] offset
);

  localparam int B_B1  = base_b1(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE, COUNT);
  localparam int B_W2  = base_w2(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE, COUNT);
  localparam int B_B2  = base_b2(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE, COUNT);
  localparam int B_DIN = base_din(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE, COUNT);

  always_comb begin
    region = RGN_W1;
    offset = load_idx;
    if (load_idx >= IW'(B_DIN)) begin
      region = RGN_DIN;
      offset = load_idx - IW'(B_DIN);
    end else if (load_idx >= IW'(B_B2)) begin
      region = RGN_B2;
      offset = load_idx - IW'(B_B2);
    end else if (load_idx >= IW'(B_W2)) begin
      region = RGN_W2;
      offset = load_idx - IW'(B_W2);
    end else if (load_idx >= IW'(B_B1)) begin
      region = RGN_B1;
      offset = load_idx - IW'(B_B1);
    end
  end

endmodule

// File: rtl/mlp_host_ctrl.sv
// Host-side initiator: loads MLP arrays from a word stream, runs the core with a
// done timeout, and streams captured results back out.
module mlp_host_ctrl
  import mlp_host_pkg::*;
#(
  parameter int INPUT_SIZE  = 4,
  parameter int HIDDEN_SIZE = 4,
  parameter int OUTPUT_SIZE = 1,
  parameter int COUNT       = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [WORD_W-1:0]                       s_data,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [WORD_W-1:0]                       m_data,
  output logic                                    busy,
  output logic                                    timeout_err,
  output logic                                    mlp_enable,
  input  logic                                    mlp_done,
  output logic                                    mlp_clear,
  output logic [INPUT_SIZE*HIDDEN_SIZE*WORD_W-1:0]  mlp_weights1,
  output logic [COUNT*HIDDEN_SIZE*WORD_W-1:0]       mlp_biases1,
  output logic [HIDDEN_SIZE*OUTPUT_SIZE*WORD_W-1:0] mlp_weights2,
  output logic [COUNT*OUTPUT_SIZE*WORD_W-1:0]       mlp_biases2,
  output logic [COUNT*INPUT_SIZE*WORD_W-1:0]        mlp_data_in,
  input  logic [COUNT*OUTPUT_SIZE*WORD_W-1:0]       mlp_data_out
);

  localparam int N_LOAD = n_load(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE, COUNT);
  localparam int N_OUT  = COUNT * OUTPUT_SIZE;
  localparam int IW     = idx_w(N_LOAD);
  localparam int OW     = idx_w(N_OUT);
  localparam int TW     = idx_w(TIMEOUT);

  // Handshakes: a word moves on s_valid&&s_ready (s_*) or m_valid&&m_ready (m_*);
  // the sender holds valid and data stable until the word is taken.
  state_t          state, state_next;
  logic [IW-1:0]   load_idx;
  logic [OW-1:0]   out_idx;
  logic [TW-1:0]   timer;
  logic [N_OUT*WORD_W-1:0] result_q;
  region_t         region;
  logic [IW-1:0]   offset;
  logic            s_fire, m_fire, load_last, out_last, timer_hit, capture, abort;

  mlp_load_decoder #(
    .INPUT_SIZE (INPUT_SIZE),
    .HIDDEN_SIZE(HIDDEN_SIZE),
    .OUTPUT_SIZE(OUTPUT_SIZE),
    .COUNT      (COUNT),
    .IW         (IW)
  ) u_decoder (
    .load_idx(load_idx),
    .region  (region),
    .offset  (offset)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = (state == LOAD) && !rst;
    m_valid    = (state == UNLOAD);
    busy       = (state != LOAD);
    s_fire     = s_valid && s_ready;
    m_fire     = m_valid && m_ready;
    load_last  = (load_idx == IW'(N_LOAD - 1));
    out_last   = (out_idx == OW'(N_OUT - 1));
    timer_hit  = (timer == TW'(TIMEOUT - 1));
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      LOAD:   if (s_fire && load_last) state_next = RUN;
      RUN: begin
        // done takes priority over a timeout landing in the same cycle
        if (mlp_done) begin
          capture    = 1'b1;
          state_next = UNLOAD;
        end else if (timer_hit) begin
          abort      = 1'b1;
          state_next = LOAD;
        end
      end
      UNLOAD: if (m_fire && out_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_idx    <= '0;
      out_idx     <= '0;
      timer       <= '0;
      mlp_enable  <= 1'b0;
      mlp_clear   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // One pulse on leaving RUN clears a sticky done before the next batch.
      mlp_clear <= capture || abort;
      timer     <= (state == RUN) ? timer + TW'(1) : '0;
      if (s_fire) load_idx <= load_last ? '0 : load_idx + IW'(1);
      if (m_fire) out_idx  <= out_last  ? '0 : out_idx + OW'(1);
      if (s_fire && load_last) mlp_enable <= 1'b1;
      if (capture || abort)    mlp_enable <= 1'b0;
      if (abort)               timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mlp_weights1 <= '0;
      mlp_biases1  <= '0;
      mlp_weights2 <= '0;
      mlp_biases2  <= '0;
      mlp_data_in  <= '0;
      result_q     <= '0;
    end else begin
      if (s_fire) begin
        case (region)
          RGN_W1:  mlp_weights1[int'(offset)*WORD_W +: WORD_W] <= s_data;
          RGN_B1:  mlp_biases1[int'(offset)*WORD_W +: WORD_W]  <= s_data;
          RGN_W2:  mlp_weights2[int'(offset)*WORD_W +: WORD_W] <= s_data;
          RGN_B2:  mlp_biases2[int'(offset)*WORD_W +: WORD_W]  <= s_data;
          RGN_DIN: mlp_data_in[int'(offset)*WORD_W +: WORD_W]  <= s_data;
          default: ;
        endcase
      end
      if (capture) result_q <= mlp_data_out;
    end
  end

  assign m_data = result_q[int'(out_idx)*WORD_W +: WORD_W];

endmodule
